tlc5620_multi_ctrl: RTL and testbench

Parametrised multi-channel controller for the TLC5620 quad 8-bit serial DAC. It replaces the single-channel fixed-pattern driver. It accepts a batch of per-channel codes through a valid/ready handshake and serialises one 11-bit frame per enabled channel. It generates the LOAD/LDAC strobes and reports completion, so the display path can show the committed codes.

---
 rtl/tlc5620_pkg.sv | 28 ++
 rtl/tlc5620_bit_timer.sv | 34 +++
 rtl/tlc5620_multi_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_tlc5620_multi_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc5620_pkg.sv
// Shared types and helpers for the TLC5620 multi-channel controller.
// TLC_SIMUL_UPDATE_EN adds the LDAC state used for simultaneous update.
package tlc5620_pkg;

    localparam int FRAME_BITS = 11;
    localparam int ADDR_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
`ifdef TLC_SIMUL_UPDATE_EN
        , ST_LDAC = 3'd5
`endif
    } state_e;

    // Frame layout on the wire, MSB first: A1 A0 RNG D7..D0
    function automatic logic [FRAME_BITS-1:0] tlc_frame(
        input logic [ADDR_W-1:0] addr,
        input logic              rng,
        input logic [7:0]        code
    );
        return {addr, rng, code};
    endfunction

endpackage

// File: rtl/tlc5620_bit_timer.sv
// Half serial-clock period divider: strobes o_half_tick every CLK_DIV enabled cycles.
// Held cleared while disabled so every batch starts phase-aligned.
module tlc5620_bit_timer
    import tlc5620_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_half_tick
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running half-period counter while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_half_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/tlc5620_multi_ctrl.sv
// Multi-channel TLC5620 batch controller: one 11-bit frame per masked channel plus LOAD strobe.
// Define TLC_SIMUL_UPDATE_EN for a single LDAC pulse after the batch (simultaneous update).
module tlc5620_multi_ctrl
    import tlc5620_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_CH*8-1:0]   req_codes,
    input  logic [NUM_CH-1:0]     req_rng,
    input  logic [NUM_CH-1:0]     req_mask,
    output logic                  dac_clk,
    output logic                  dac_data,
    output logic                  load,
    output logic                  ldac,
    output logic                  busy,
    output logic                  done
);

    state_e                  r_state;
    logic [NUM_CH*8-1:0]     r_codes;
    logic [NUM_CH-1:0]       r_rng;
    logic [NUM_CH-1:0]       r_pending;
    logic [3:0]              r_bit_cnt;
    logic                    r_half;
    logic [FRAME_BITS-2:0]   r_shift;
    logic                    r_dac_clk;
    logic                    r_dac_data;
    logic                    r_load;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ready;
`ifdef TLC_SIMUL_UPDATE_EN
    logic                    r_ldac;
`endif

    logic                    w_accept;
    logic                    w_any;
    logic                    w_start;
    logic                    w_half_tick;
    logic [NUM_CH-1:0]       w_src_mask;
    logic [NUM_CH-1:0]       w_src_rng;
    logic [NUM_CH-1:0]       w_rest;
    logic [NUM_CH*8-1:0]     w_src_codes;
    logic [ADDR_W-1:0]       w_next_ch;
    logic [7:0]              w_code;
    logic                    w_rng;
    logic [FRAME_BITS-1:0]   w_frame;

    // Ready is only high in IDLE/DONE, so acceptance implies one of those states
    assign w_accept = req_valid && r_ready;

    // Lowest pending channel; on acceptance the fresh request is searched directly
    always_comb begin
        w_src_mask  = w_accept ? req_mask  : r_pending;
        w_src_rng   = w_accept ? req_rng   : r_rng;
        w_src_codes = w_accept ? req_codes : r_codes;
        w_next_ch   = '0;
        w_code      = 8'h00;
        w_rng       = 1'b0;
        w_rest      = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            w_next_ch = w_src_mask[n] ? ADDR_W'(n) : w_next_ch;
            w_code    = w_src_mask[n] ? w_src_codes[8*n +: 8] : w_code;
            w_rng     = w_src_mask[n] ? w_src_rng[n] : w_rng;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            w_rest[n] = w_src_mask[n] && (ADDR_W'(n) != w_next_ch);
        end
    end

    assign w_any   = |w_src_mask;
    assign w_frame = tlc_frame(w_next_ch, w_rng, w_code);
    assign w_start = (w_accept && w_any) ||
                     ((r_state == ST_GAP) && w_half_tick && w_any);

    tlc5620_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst),
        .i_en        (r_busy),
        .o_half_tick (w_half_tick)
    );

    // Batch sequencer with registered pin outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_codes    <= '0;
            r_rng      <= '0;
            r_pending  <= '0;
            r_bit_cnt  <= 4'd0;
            r_half     <= 1'b0;
            r_shift    <= '0;
            r_dac_clk  <= 1'b1;
            r_dac_data <= 1'b0;
            r_load     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
`ifdef TLC_SIMUL_UPDATE_EN
            r_ldac     <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_codes <= req_codes;
                        r_rng   <= req_rng;
                        if (w_any) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_half_tick) begin
                        if (!r_half) begin
                            r_dac_clk <= 1'b0;
                            r_half    <= 1'b1;
                        end else if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
                            r_state    <= ST_LOAD;
                            r_dac_clk  <= 1'b1;
                            r_dac_data <= 1'b0;
                            r_load     <= 1'b0;
                            r_half     <= 1'b0;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            r_shift    <= {r_shift[FRAME_BITS-3:0], 1'b0};
                            r_dac_data <= r_shift[FRAME_BITS-2];
                            r_dac_clk  <= 1'b1;
                            r_half     <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_half_tick) begin
                        r_load  <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_half_tick) begin
                        if (w_any) begin
                            r_state <= ST_SHIFT;
                        end else begin
`ifdef TLC_SIMUL_UPDATE_EN
                            r_state <= ST_LDAC;
                            r_ldac  <= 1'b0;
                            r_half  <= 1'b0;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
`endif
                        end
                    end
                end
`ifdef TLC_SIMUL_UPDATE_EN
                ST_LDAC: begin
                    if (w_half_tick) begin
                        if (!r_half) begin
                            r_ldac <= 1'b1;
                            r_half <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Loading a new channel presents its MSB on the very next cycle
            if (w_start) begin
                r_pending  <= w_rest;
                r_shift    <= w_frame[FRAME_BITS-2:0];
                r_dac_data <= w_frame[FRAME_BITS-1];
                r_dac_clk  <= 1'b1;
                r_half     <= 1'b0;
                r_bit_cnt  <= 4'd0;
            end
        end
    end

    assign req_ready = r_ready;
    assign dac_clk   = r_dac_clk;
    assign dac_data  = r_dac_data;
    assign load      = r_load;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef TLC_SIMUL_UPDATE_EN
    assign ldac      = r_ldac;
`else
    assign ldac      = 1'b0;
`endif

endmodule

// File: tb/tb_tlc5620_multi_ctrl.sv
// Directed bench for tlc5620_multi_ctrl: vector table plus reset, back-to-back and divider sequences.
module tb_tlc5620_multi_ctrl;

    localparam int DIV  = 1;
    localparam int DIVB = 3;
`ifdef TLC_SIMUL_UPDATE_EN
    localparam int   MAC      = 1;
    localparam logic LDAC_RST = 1'b1;
`else
    localparam int   MAC      = 0;
    localparam logic LDAC_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [31:0] req_codes = 32'h0;
    logic [3:0]  req_rng = 4'h0;
    logic [3:0]  req_mask = 4'h0;

    logic a_ready, a_dac_clk, a_dac_data, a_load, a_ldac, a_busy, a_done;
    logic b_ready, b_dac_clk, b_dac_data, b_load, b_ldac, b_busy, b_done;

    always #5 clk = ~clk;

    tlc5620_multi_ctrl #(.NUM_CH(4), .CLK_DIV(DIV)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
        .req_codes(req_codes), .req_rng(req_rng), .req_mask(req_mask),
        .dac_clk(a_dac_clk), .dac_data(a_dac_data), .load(a_load), .ldac(a_ldac),
        .busy(a_busy), .done(a_done)
    );

    tlc5620_multi_ctrl #(.NUM_CH(4), .CLK_DIV(DIVB)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_codes(req_codes), .req_rng(req_rng), .req_mask(req_mask),
        .dac_clk(b_dac_clk), .dac_data(b_dac_data), .load(b_load), .ldac(b_ldac),
        .busy(b_busy), .done(b_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Pin monitors, sampled 1 time unit after each rising clock edge
    logic [10:0] a_bits = 11'h0;
    logic [10:0] a_frames[$];
    int          a_falls = 0, a_lfalls = 0, a_ldfalls = 0;
    logic        a_pclk = 1'b1, a_pload = 1'b1, a_pldac = LDAC_RST;
    logic [10:0] b_bits = 11'h0;
    logic [10:0] b_frames[$];
    int          b_falls = 0, b_lowcnt = 0, b_lowmax = 0;
    logic        b_pclk = 1'b1, b_pload = 1'b1;

    always begin
        @(posedge clk);
        #1;
        if (a_pclk && !a_dac_clk) begin
            a_bits = {a_bits[9:0], a_dac_data};
            a_falls++;
        end
        if (a_pload && !a_load) begin
            a_lfalls++;
            a_frames.push_back(a_bits);
        end
        if (a_pldac && !a_ldac) a_ldfalls++;
        a_pclk  = a_dac_clk;
        a_pload = a_load;
        a_pldac = a_ldac;
        if (b_pclk && !b_dac_clk) begin
            b_bits = {b_bits[9:0], b_dac_data};
            b_falls++;
        end
        if (b_pload && !b_load) b_frames.push_back(b_bits);
        if (!b_dac_clk) begin
            b_lowcnt++;
        end else begin
            if (b_lowcnt > b_lowmax) b_lowmax = b_lowcnt;
            b_lowcnt = 0;
        end
        b_pclk  = b_dac_clk;
        b_pload = b_load;
    end

    task automatic clear_mon();
        a_falls = 0; a_lfalls = 0; a_ldfalls = 0; a_frames.delete();
        b_falls = 0; b_lowcnt = 0; b_lowmax = 0; b_frames.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac_clk"},  a_dac_clk,  1'b1);
        chk({tag, "_dac_data"}, a_dac_data, 1'b0);
        chk({tag, "_load"},     a_load,     1'b1);
        chk({tag, "_ldac"},     a_ldac,     LDAC_RST);
        chk({tag, "_busy"},     a_busy,     1'b0);
        chk({tag, "_done"},     a_done,     1'b0);
        chk({tag, "_ready"},    a_ready,    1'b1);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] codes;
        logic [3:0]  rng;
        int          lat;
        int          loads;
        logic [10:0] first;
        logic [10:0] last;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int id, input vec_t v);
        int          lat;
        logic        busy_ok, rdy_ok;
        int          exp_lat;
        logic [10:0] exp_frame;
        int          fi;
        clear_mon();
        @(negedge clk);
        chk($sformatf("v%0d_ready_pre", id), a_ready, 1'b1);
        req_mask  = v.mask;
        req_codes = v.codes;
        req_rng   = v.rng;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_codes = ~v.codes;
        req_mask  = 4'hF;
        req_rng   = ~v.rng;
        lat = 1; busy_ok = 1'b1; rdy_ok = 1'b1;
        while (!a_done && lat < 400) begin
            if (a_busy !== 1'b1) busy_ok = 1'b0;
            if (a_ready !== 1'b0) rdy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        exp_lat = v.lat + ((MAC != 0 && v.mask != 4'h0) ? 2 * DIV : 0);
        chk($sformatf("v%0d_latency", id), lat, exp_lat);
        chk($sformatf("v%0d_busy_during", id), busy_ok, 1'b1);
        chk($sformatf("v%0d_ready_during", id), rdy_ok, 1'b1);
        chk($sformatf("v%0d_busy_at_done", id), a_busy, 1'b0);
        chk($sformatf("v%0d_ready_at_done", id), a_ready, 1'b1);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", id), a_done, 1'b0);
        chk($sformatf("v%0d_clk_falls", id), a_falls, 11 * v.loads);
        chk($sformatf("v%0d_load_pulses", id), a_lfalls, v.loads);
        chk($sformatf("v%0d_ldac_pulses", id), a_ldfalls, (MAC != 0 && v.loads > 0) ? 1 : 0);
        chk($sformatf("v%0d_frame_count", id), a_frames.size(), v.loads);
        if (v.loads > 0 && a_frames.size() == v.loads) begin
            chk($sformatf("v%0d_first_frame", id), a_frames[0], v.first);
            chk($sformatf("v%0d_last_frame", id), a_frames[v.loads-1], v.last);
            fi = 0;
            for (int n = 0; n < 4; n++) begin
                if (v.mask[n]) begin
                    exp_frame = {n[1:0], v.rng[n], v.codes[8*n +: 8]};
                    chk($sformatf("v%0d_frame_ch%0d", id, n), a_frames[fi], exp_frame);
                    fi++;
                end
            end
        end
    endtask

    int   lat;
    logic done_seen;

    initial begin
        vecs[0] = '{mask: 4'b0001, codes: 32'h000000A5, rng: 4'b0000, lat: 25, loads: 1, first: 11'h0A5, last: 11'h0A5};
        vecs[1] = '{mask: 4'b1010, codes: 32'hFF003C00, rng: 4'b1000, lat: 49, loads: 2, first: 11'h23C, last: 11'h7FF};
        vecs[2] = '{mask: 4'b0000, codes: 32'hDEADBEEF, rng: 4'b1111, lat: 1,  loads: 0, first: 11'h000, last: 11'h000};
        vecs[3] = '{mask: 4'b1111, codes: 32'h78563412, rng: 4'b0110, lat: 97, loads: 4, first: 11'h012, last: 11'h678};
        vecs[4] = '{mask: 4'b0100, codes: 32'h00000000, rng: 4'b0100, lat: 25, loads: 1, first: 11'h500, last: 11'h500};
        vecs[5] = '{mask: 4'b1001, codes: 32'h80FFFF01, rng: 4'b0001, lat: 49, loads: 2, first: 11'h101, last: 11'h680};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("idle");

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset asserted in the middle of a frame
        clear_mon();
        @(negedge clk);
        req_mask = 4'b0001; req_codes = 32'h000000A5; req_rng = 4'b0000; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (a_falls < 5 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("midrst_reached_bit5", (a_falls >= 5) ? 1'b1 : 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_done) done_seen = 1'b1;
        end
        chk("midrst_no_load", a_lfalls, 0);
        chk("midrst_no_done", done_seen, 1'b0);
        chk("midrst_ready", a_ready, 1'b1);

        // Back-to-back batches with req_valid held high
        clear_mon();
        @(negedge clk);
        req_mask = 4'b0001; req_codes = 32'h00000011; req_rng = 4'b0000; req_valid = 1'b1;
        @(negedge clk);
        req_mask = 4'b0010; req_codes = 32'h00009900;
        lat = 1;
        while (!a_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat1", lat, 25 + 2 * DIV * MAC);
        @(negedge clk);
        chk("b2b_accept_busy", a_busy, 1'b1);
        chk("b2b_accept_ready", a_ready, 1'b0);
        chk("b2b_accept_done", a_done, 1'b0);
        req_valid = 1'b0; req_codes = 32'hAAAAAAAA; req_mask = 4'hF; req_rng = 4'hF;
        lat = 1;
        while (!a_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat2", lat, 25 + 2 * DIV * MAC);
        @(negedge clk);
        chk("b2b_loads", a_lfalls, 2);
        chk("b2b_frames", a_frames.size(), 2);
        if (a_frames.size() == 2) begin
            chk("b2b_frame1", a_frames[0], 11'h011);
            chk("b2b_frame2", a_frames[1], 11'h299);
        end

        // Divider check on the CLK_DIV=3 instance
        clear_mon();
        @(negedge clk);
        req_mask = 4'b0010; req_codes = 32'h00005A00; req_rng = 4'b0010; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        lat = 1;
        while (!b_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("div3_latency", lat, 1 + 24 * DIVB + 2 * DIVB * MAC);
        @(negedge clk);
        chk("div3_falls", b_falls, 11);
        chk("div3_low_width", b_lowmax, DIVB);
        chk("div3_frames", b_frames.size(), 1);
        if (b_frames.size() == 1) chk("div3_frame", b_frames[0], 11'h35A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
